// File: rtl/clock_sequencer_if.sv
// Bundle between the clock sequencer and the BCD time register / button front end.
// master: the sequencer side; slave: time register plus button and prescaler sources.
interface clock_sequencer_if;
   logic        tick;
   logic        btn_mode;
   logic        btn_adjust;
   logic [23:0] time_bcd;
   logic        will_wraparound_hours;
   logic        will_wraparound_minutes;
   logic        will_wraparound_seconds;
   logic        increment_hours;
   logic        increment_minutes;
   logic        increment_seconds;
   logic        load_new;
   logic [23:0] time_to_load_bcd;
   logic        blank_hours;
   logic        blank_minutes;
   logic        setting;

   modport master (
      input  tick, btn_mode, btn_adjust, time_bcd,
      input  will_wraparound_hours, will_wraparound_minutes, will_wraparound_seconds,
      output increment_hours, increment_minutes, increment_seconds,
      output load_new, time_to_load_bcd, blank_hours, blank_minutes, setting
   );

   modport slave (
      output tick, btn_mode, btn_adjust, time_bcd,
      output will_wraparound_hours, will_wraparound_minutes, will_wraparound_seconds,
      input  increment_hours, increment_minutes, increment_seconds,
      input  load_new, time_to_load_bcd, blank_hours, blank_minutes, setting
   );
endinterface

// File: rtl/clock_sequencer.sv
// Seconds strobe generation, cascaded increments, RUN/SET_HOURS/SET_MINUTES control
// and blink masks for the 7-segment clock's BCD time register.
module clock_sequencer #(
   parameter int unsigned TICKS_PER_SECOND = 8
) (
   input logic               clk,
   input logic               reset,
   clock_sequencer_if.master bus
);

   localparam int unsigned PcntW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
   localparam logic [PcntW-1:0] PcntMax  = PcntW'(TICKS_PER_SECOND - 1);
   localparam logic [PcntW-1:0] PcntHalf = PcntW'(TICKS_PER_SECOND / 2 - 1);

   localparam logic [1:0] StRun        = 2'd0;
   localparam logic [1:0] StSetHours   = 2'd1;
   localparam logic [1:0] StSetMinutes = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PcntW-1:0] pcnt_q, pcnt_d;
   logic             bph_q, bph_d;
   logic             inc_h_q, inc_h_d;
   logic             inc_m_q, inc_m_d;
   logic             inc_s_q, inc_s_d;
   logic             load_new_q, load_new_d;
   logic [23:0]      load_val_q, load_val_d;
   logic             blank_h_q, blank_h_d;
   logic             blank_m_q, blank_m_d;
   logic             setting_q, setting_d;

   logic sec_strobe;
   logic half_strobe;
   logic set_exit;
   logic adjust;
   logic in_run;

   always_comb begin
      sec_strobe  = bus.tick && (pcnt_q == PcntMax);
      half_strobe = bus.tick && (pcnt_q == PcntHalf);
      set_exit    = (state_q == StSetMinutes) && bus.btn_mode;
      // a mode press swallows a coincident adjust press
      adjust      = bus.btn_adjust && !bus.btn_mode;
      in_run      = (state_q == StRun);
   end

   always_comb begin
      state_d = state_q;
      if (bus.btn_mode) begin
         case (state_q)
            StRun:        state_d = StSetHours;
            StSetHours:   state_d = StSetMinutes;
            StSetMinutes: state_d = StRun;
            default:      state_d = StRun;
         endcase
      end
   end

   always_comb begin
      pcnt_d = pcnt_q;
      if (set_exit) begin
         pcnt_d = '0;
      end else if (bus.tick) begin
         pcnt_d = (pcnt_q == PcntMax) ? '0 : pcnt_q + PcntW'(1);
      end
   end

   always_comb begin
      bph_d = bph_q;
      if (state_d == StRun) begin
         bph_d = 1'b1;
      end else if (half_strobe || sec_strobe) begin
         bph_d = ~bph_q;
      end
   end

   always_comb begin
      inc_s_d = in_run && sec_strobe;
      inc_m_d = (in_run && sec_strobe && bus.will_wraparound_seconds) ||
                ((state_q == StSetMinutes) && adjust);
      inc_h_d = (in_run && sec_strobe && bus.will_wraparound_seconds &&
                 bus.will_wraparound_minutes) ||
                ((state_q == StSetHours) && adjust);
      load_new_d = set_exit;
      load_val_d = set_exit ? {bus.time_bcd[23:8], 8'h00} : load_val_q;
      blank_h_d  = (state_d == StSetHours) && !bph_d;
      blank_m_d  = (state_d == StSetMinutes) && !bph_d;
      setting_d  = (state_d == StSetHours) || (state_d == StSetMinutes);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StRun;
         pcnt_q     <= '0;
         bph_q      <= 1'b1;
         inc_h_q    <= 1'b0;
         inc_m_q    <= 1'b0;
         inc_s_q    <= 1'b0;
         load_new_q <= 1'b0;
         load_val_q <= '0;
         blank_h_q  <= 1'b0;
         blank_m_q  <= 1'b0;
         setting_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         bph_q      <= bph_d;
         inc_h_q    <= inc_h_d;
         inc_m_q    <= inc_m_d;
         inc_s_q    <= inc_s_d;
         load_new_q <= load_new_d;
         load_val_q <= load_val_d;
         blank_h_q  <= blank_h_d;
         blank_m_q  <= blank_m_d;
         setting_q  <= setting_d;
      end
   end

   assign bus.increment_hours   = inc_h_q;
   assign bus.increment_minutes = inc_m_q;
   assign bus.increment_seconds = inc_s_q;
   assign bus.load_new          = load_new_q;
   assign bus.time_to_load_bcd  = load_val_q;
   assign bus.blank_hours       = blank_h_q;
   assign bus.blank_minutes     = blank_m_q;
   assign bus.setting           = setting_q;

endmodule

// File: tb/tb_clock_sequencer.sv
// Directed bench for clock_sequencer with TICKS_PER_SECOND=4 and a BCD time register model.
module tb_clock_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic done;

  logic [23:0] tm;
  logic [23:0] preset_val;
  logic        preset_req;

  clock_sequencer_if bus ();

  clock_sequencer #(
    .TICKS_PER_SECOND(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  // Time register model: the environment the sequencer drives.
  always @(posedge clk) begin
    if (preset_req) begin
      tm <= preset_val;
    end else if (bus.load_new) begin
      tm <= bus.time_to_load_bcd;
    end else begin
      if (bus.increment_seconds) tm[7:0]   <= bcd_inc(tm[7:0], 8'h59);
      if (bus.increment_minutes) tm[15:8]  <= bcd_inc(tm[15:8], 8'h59);
      if (bus.increment_hours)   tm[23:16] <= bcd_inc(tm[23:16], 8'h23);
    end
  end

  assign bus.time_bcd                = tm;
  assign bus.will_wraparound_seconds = (tm[7:0] == 8'h59);
  assign bus.will_wraparound_minutes = (tm[15:8] == 8'h59);
  assign bus.will_wraparound_hours   = (tm[23:16] == 8'h23);

  task automatic fail(input string tag);
    failures++;
    $error("FAIL %s", tag);
  endtask

  // Drive at a negedge, let the posedge sample, return at the next negedge.
  task automatic cyc(input logic t, input logic m, input logic a);
    bus.tick       = t;
    bus.btn_mode   = m;
    bus.btn_adjust = a;
    @(negedge clk);
  endtask

  task automatic preset(input logic [23:0] v);
    bus.tick       = 1'b0;
    bus.btn_mode   = 1'b0;
    bus.btn_adjust = 1'b0;
    preset_val     = v;
    preset_req     = 1'b1;
    @(negedge clk);
    preset_req     = 1'b0;
  endtask

  initial begin
    #200000;
    if (!done) begin
      failures++;
      $error("FAIL timeout: bench did not complete within the wait limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    done           = 1'b0;
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    preset_req     = 1'b0;
    preset_val     = 24'h0;
    tm             = 24'h0;
    bus.tick       = 1'b0;
    bus.btn_mode   = 1'b0;
    bus.btn_adjust = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    checks++;
    if ({bus.increment_seconds, bus.increment_minutes, bus.increment_hours, bus.load_new,
         bus.time_to_load_bcd, bus.setting, bus.blank_hours, bus.blank_minutes} !== '0) begin
      fail("rst_all");
    end
    checks++; if (bus.increment_seconds !== 1'b0) fail("rst_inc_s");
    checks++; if (bus.increment_minutes !== 1'b0) fail("rst_inc_m");
    checks++; if (bus.increment_hours !== 1'b0) fail("rst_inc_h");
    checks++; if (bus.load_new !== 1'b0) fail("rst_load");
    checks++; if (bus.time_to_load_bcd !== 24'h0) fail("rst_load_val");
    checks++; if (bus.setting !== 1'b0) fail("rst_setting");
    checks++; if (bus.blank_hours !== 1'b0) fail("rst_blank_h");
    checks++; if (bus.blank_minutes !== 1'b0) fail("rst_blank_m");

    // 12:34:56 plus 8 ticks: strobe after every 4th tick
    preset(24'h123456);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (bus.increment_seconds !== logic'(i % 4 == 0)) fail("t1_inc_s");
      checks++; if (bus.increment_minutes !== 1'b0) fail("t1_inc_m");
      checks++; if (bus.blank_hours !== 1'b0) fail("t1_blank_h");
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (tm !== 24'h123458) fail("t1_time");

    // 09:59:59 plus one second: full cascade in one cycle
    preset(24'h095959);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b0);
    checks++; if (bus.increment_seconds !== 1'b1) fail("t2_inc_s");
    checks++; if (bus.increment_minutes !== 1'b1) fail("t2_inc_m");
    checks++; if (bus.increment_hours !== 1'b1) fail("t2_inc_h");
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (tm !== 24'h100000) fail("t2_time");

    // enter SET_HOURS, three adjusts
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (bus.setting !== 1'b1) fail("t3_setting");
    checks++; if (bus.blank_hours !== 1'b0) fail("t3_blank_h0");
    checks++; if (bus.increment_hours !== 1'b0) fail("t3_inc_h0");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      checks++; if (bus.increment_hours !== 1'b1) fail("t3_adj_inc_h");
      checks++; if (bus.increment_minutes !== 1'b0) fail("t3_adj_inc_m");
      checks++; if (bus.increment_seconds !== 1'b0) fail("t3_adj_inc_s");
      cyc(1'b0, 1'b0, 1'b0);
      checks++; if (bus.increment_hours !== 1'b0) fail("t3_gap_inc_h");
    end
    checks++; if (tm !== 24'h130000) fail("t3_time");
    // blink toggles at pcnt 1 and 3: blank pattern 0,1,1,0; time frozen
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (bus.increment_seconds !== 1'b0) fail("t3_frozen_inc_s");
      checks++; if (bus.blank_hours !== logic'(i == 2 || i == 3)) fail("t3_blink_h");
    end

    // SET_MINUTES: adjust at mm=59 wraps without carry
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (bus.setting !== 1'b1) fail("t4_setting");
    checks++; if (bus.blank_hours !== 1'b0) fail("t4_blank_h");
    checks++; if (bus.blank_minutes !== 1'b0) fail("t4_blank_m0");
    preset(24'h135912);
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (bus.increment_minutes !== 1'b1) fail("t4_inc_m");
    checks++; if (bus.increment_hours !== 1'b0) fail("t4_inc_h");
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (tm !== 24'h130012) fail("t4_time");
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (bus.blank_minutes !== logic'(i >= 2)) fail("t4_blink_m");
    end
    // exit with a tick at pcnt=3: strobe suppressed, pcnt cleared
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (bus.load_new !== 1'b1) fail("t4_load");
    checks++; if (bus.time_to_load_bcd !== 24'h130000) fail("t4_load_val");
    checks++; if (bus.increment_seconds !== 1'b0) fail("t4_exit_inc_s");
    checks++; if (bus.setting !== 1'b0) fail("t4_exit_setting");
    checks++; if (bus.blank_minutes !== 1'b0) fail("t4_exit_blank_m");
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (bus.load_new !== 1'b0) fail("t4_load_once");
    checks++; if (tm !== 24'h130000) fail("t4_loaded_time");
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++; if (bus.increment_seconds !== logic'(i == 4)) fail("t4_first_sec");
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (tm !== 24'h130001) fail("t4_time_after");

    // mode and adjust together in RUN: mode wins
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (bus.setting !== 1'b1) fail("t5_setting");
    checks++; if (bus.increment_hours !== 1'b0) fail("t5_inc_h");
    checks++; if (bus.increment_minutes !== 1'b0) fail("t5_inc_m");
    checks++; if (bus.increment_seconds !== 1'b0) fail("t5_inc_s");

    // asynchronous reset mid-SET_MINUTES
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (bus.increment_minutes !== 1'b1) fail("t6_pre_inc_m");
    bus.btn_adjust = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.increment_minutes !== 1'b0) fail("t6_rst_inc_m");
    checks++; if (bus.setting !== 1'b0) fail("t6_rst_setting");
    checks++; if (bus.blank_minutes !== 1'b0) fail("t6_rst_blank_m");
    checks++; if (bus.time_to_load_bcd !== 24'h0) fail("t6_rst_load_val");
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (bus.load_new !== 1'b0) fail("t6_no_load");
    checks++; if (bus.setting !== 1'b0) fail("t6_setting");
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (bus.increment_hours !== 1'b0) fail("t6_run_adj_h");
    checks++; if (bus.increment_minutes !== 1'b0) fail("t6_run_adj_m");
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (bus.setting !== 1'b1) fail("t6_to_set_h");
    checks++; if (bus.load_new !== 1'b0) fail("t6_to_set_load");
    checks++; if (tm !== 24'h130001) fail("t6_time");

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
